// File: rtl/adder_arb_pkg.sv
// Shared constants and helpers for the adder arbiter block.
// Holds the default operand width, the requester-id width function and the counter type.
package adder_arb_pkg;

  localparam int DEFAULT_WIDTH = 25;
  localparam int CNT_WIDTH     = 16;

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

  // A single requester still needs a one-bit id so that port widths stay legal.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_arbiter_rr.sv
// Round-robin arbiter: scans the request vector starting at ptr, wrapping modulo NUM_REQ,
// and returns the first hit as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               grant_valid
);

  int cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = (int'(ptr) + off) % NUM_REQ;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDW'(cand);
        grant       = NUM_REQ'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/adder_datapath.sv
// Combinational adder datapath: WIDTH-bit sum plus the carry out of the top bit.
module adder_datapath #(
  parameter int WIDTH = 25
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_arbiter.sv
// Multi-requester adder: round-robin grant into a two-stage pipeline (operands, then sum)
// with backpressure from rsp_ready, plus saturating handshake and overflow counters.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]    req_a,
  input  logic [NUM_REQ*WIDTH-1:0]    req_b,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [id_width(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]            rsp_sum,
  output logic                        rsp_overflow,
  input  logic                        stats_clr,
  output cnt_t                        op_count,
  output cnt_t                        ovf_count
);

  localparam int IDW = id_width(NUM_REQ);

  logic [IDW-1:0]     ptr;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx;
  logic               grant_valid;

  logic               s1_valid;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  logic [IDW-1:0]     s1_id;

  logic [WIDTH-1:0]   add_sum;
  logic               add_carry;

  logic               s2_free;
  logic               s1_free;
  logic               accept;
  logic               rsp_fire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req         (req_valid),
    .ptr         (ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  adder_datapath #(
    .WIDTH (WIDTH)
  ) u_add (
    .a     (s1_a),
    .b     (s1_b),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // S1 may load whenever it is empty or draining into S2 in the same cycle.
  assign s2_free   = !rsp_valid || rsp_ready;
  assign s1_free   = !s1_valid || s2_free;
  assign accept    = grant_valid && s1_free && rst_n;
  assign req_ready = accept ? grant : '0;
  assign rsp_fire  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
      s1_b     <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
      s1_id    <= grant_idx;
    end else if (s2_free) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid    <= 1'b0;
      rsp_sum      <= '0;
      rsp_overflow <= 1'b0;
      rsp_id       <= '0;
    end else if (s2_free) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_sum      <= add_sum;
        rsp_overflow <= add_carry;
        rsp_id       <= s1_id;
      end
    end
  end

  // A clear wins over any increment landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count  <= '0;
      ovf_count <= '0;
    end else if (stats_clr) begin
      op_count  <= '0;
      ovf_count <= '0;
    end else if (rsp_fire) begin
      if (op_count != CNT_MAX) begin
        op_count <= op_count + cnt_t'(1);
      end
      if (rsp_overflow && (ovf_count != CNT_MAX)) begin
        ovf_count <= ovf_count + cnt_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed vector table, hand-written pipeline sequences and a
// randomized phase, all checked against a transaction-level queue model.
module tb_adder_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 25;
  localparam int IDW     = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_overflow;
  logic                     stats_clr;
  logic [15:0]              op_count;
  logic [15:0]              ovf_count;

  adder_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_sum      (rsp_sum),
    .rsp_overflow (rsp_overflow),
    .stats_clr    (stats_clr),
    .op_count     (op_count),
    .ovf_count    (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction-level model: FIFO of accepted operations, each visible two cycles after acceptance.
  typedef struct {
    int               id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    longint           t;
  } txn_t;

  txn_t               m_q[$];
  txn_t               m_new;
  int                 m_ptr;
  longint             m_cycle;
  int                 m_op;
  int                 m_ovf;
  logic [NUM_REQ-1:0] acc_mask;
  int                 exp_idx;
  logic               exp_valid;
  logic               can_acc;
  logic               hs;
  logic [NUM_REQ-1:0] exp_ready;
  logic [WIDTH:0]     full_sum;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_ptr    = 0;
      m_cycle  = 0;
      m_op     = 0;
      m_ovf    = 0;
      acc_mask = '0;
      checkOutput("rst_req_ready", req_ready, 0);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_op_count", op_count, 0);
      checkOutput("rst_ovf_count", ovf_count, 0);
    end else begin
      exp_idx = -1;
      for (int off = 0; off < NUM_REQ; off++) begin
        if (exp_idx < 0 && req_valid[(m_ptr + off) % NUM_REQ]) exp_idx = (m_ptr + off) % NUM_REQ;
      end
      exp_valid = (m_q.size() > 0) && (m_cycle >= m_q[0].t + 2);
      can_acc   = (m_q.size() < 2) || rsp_ready;
      exp_ready = (exp_idx >= 0 && can_acc) ? (NUM_REQ'(1) << exp_idx) : '0;
      full_sum  = '0;
      checkOutput("req_ready", req_ready, exp_ready);
      checkOutput("rsp_valid", rsp_valid, exp_valid);
      if (exp_valid) begin
        full_sum = {1'b0, m_q[0].a} + {1'b0, m_q[0].b};
        checkOutput("rsp_id", rsp_id, m_q[0].id);
        checkOutput("rsp_sum", rsp_sum, full_sum[WIDTH-1:0]);
        checkOutput("rsp_overflow", rsp_overflow, full_sum[WIDTH]);
      end
      checkOutput("op_count", op_count, m_op);
      checkOutput("ovf_count", ovf_count, m_ovf);
      hs = exp_valid && rsp_ready;
      if (stats_clr) begin
        m_op  = 0;
        m_ovf = 0;
      end else if (hs) begin
        if (m_op < 65535) m_op++;
        if (full_sum[WIDTH] && m_ovf < 65535) m_ovf++;
      end
      if (hs) void'(m_q.pop_front());
      if (exp_ready != '0) begin
        m_new.id = exp_idx;
        m_new.a  = req_a[exp_idx*WIDTH +: WIDTH];
        m_new.b  = req_b[exp_idx*WIDTH +: WIDTH];
        m_new.t  = m_cycle;
        m_q.push_back(m_new);
        m_ptr = (exp_idx + 1) % NUM_REQ;
      end
      acc_mask = exp_ready;
      m_cycle++;
    end
  end

  typedef struct {
    int               id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             ovf;
    int               ovf_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic applyStimulus(input vec_t v);
    @(posedge clk); #1;
    req_valid = NUM_REQ'(1) << v.id;
    req_a[v.id*WIDTH +: WIDTH] = v.a;
    req_b[v.id*WIDTH +: WIDTH] = v.b;
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    stats_clr = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic setAllOperands(input int base);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = WIDTH'(base + i);
      req_b[i*WIDTH +: WIDTH] = WIDTH'(1 + 10 * i);
    end
  endtask

  function automatic logic [WIDTH-1:0] randOperand();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return WIDTH'($urandom_range(0, 3));
      default: return WIDTH'($urandom);
    endcase
  endfunction

  task automatic randomPhase(input int ncycles);
    for (int c = 0; c < ncycles; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && acc_mask[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 99) < 60) begin
          req_valid[i] = 1'b1;
          req_a[i*WIDTH +: WIDTH] = randOperand();
          req_b[i*WIDTH +: WIDTH] = randOperand();
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
      stats_clr = ($urandom_range(0, 99) < 2);
    end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    stats_clr = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  int               acc;
  logic             held;
  logic [WIDTH-1:0] held_sum;
  logic [IDW-1:0]   held_id;
  logic             held_ovf;

  initial begin
    vecs[0] = '{id: 2, a: 25'd5,        b: 25'd7,        sum: 25'd12,        ovf: 1'b0, ovf_cnt: 0};
    vecs[1] = '{id: 0, a: 25'h1FFFFFF,  b: 25'd1,        sum: 25'd0,         ovf: 1'b1, ovf_cnt: 1};
    vecs[2] = '{id: 1, a: 25'h1FFFFFF,  b: 25'h1FFFFFF,  sum: 25'h1FFFFFE,   ovf: 1'b1, ovf_cnt: 2};
    vecs[3] = '{id: 3, a: 25'h1000000,  b: 25'h1000000,  sum: 25'd0,         ovf: 1'b1, ovf_cnt: 3};
    vecs[4] = '{id: 0, a: 25'h0ABCDEF,  b: 25'h1234567,  sum: 25'h1CF1356,   ovf: 1'b0, ovf_cnt: 3};
    vecs[5] = '{id: 3, a: 25'd0,        b: 25'd0,        sum: 25'd0,         ovf: 1'b0, ovf_cnt: 3};

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    stats_clr = 1'b0;
    @(negedge clk);
    checkOutput("reset_rsp_sum", rsp_sum, 0);
    checkOutput("reset_rsp_id", rsp_id, 0);
    checkOutput("reset_rsp_overflow", rsp_overflow, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    for (int n = 0; n < 6; n++) begin
      applyStimulus(vecs[n]);
      @(negedge clk);
      checkOutput("vec_ready", req_ready, NUM_REQ'(1) << vecs[n].id);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      checkOutput("vec_lat1_valid", rsp_valid, 0);
      @(negedge clk);
      checkOutput("vec_rsp_valid", rsp_valid, 1);
      checkOutput("vec_rsp_sum", rsp_sum, vecs[n].sum);
      checkOutput("vec_rsp_id", rsp_id, vecs[n].id);
      checkOutput("vec_rsp_ovf", rsp_overflow, vecs[n].ovf);
      @(negedge clk);
      checkOutput("vec_op_count", op_count, n + 1);
      checkOutput("vec_ovf_count", ovf_count, vecs[n].ovf_cnt);
    end

    // Round-robin streaming with all requesters active.
    doReset();
    @(posedge clk); #1;
    setAllOperands(100);
    req_valid = '1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 5) checkOutput("rr_grant", req_ready, NUM_REQ'(1) << (k % 4));
      if (k >= 2) begin
        checkOutput("rr_rsp_valid", rsp_valid, 1);
        checkOutput("rr_rsp_id", rsp_id, (k - 2) % 4);
      end
      if (k == 4) begin
        @(posedge clk); #1;
        req_valid = '0;
      end
    end
    repeat (3) @(posedge clk);

    // Backpressure for five cycles while everyone requests.
    #1;
    rsp_ready = 1'b0;
    req_valid = '1;
    acc  = 0;
    held = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      acc += $countones(req_ready & req_valid);
      if (rsp_valid) begin
        if (!held) begin
          held     = 1'b1;
          held_sum = rsp_sum;
          held_id  = rsp_id;
          held_ovf = rsp_overflow;
        end else begin
          checkOutput("stall_sum_stable", rsp_sum, held_sum);
          checkOutput("stall_id_stable", rsp_id, held_id);
          checkOutput("stall_ovf_stable", rsp_overflow, held_ovf);
        end
      end
    end
    checkOutput("stall_accepts", acc, 2);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = '0;
    repeat (4) @(negedge clk);
    checkOutput("stall_drained_count", op_count, 7);
    checkOutput("stall_drained_valid", rsp_valid, 0);

    randomPhase(3000);

    // Reset asserted with both stages occupied.
    @(posedge clk); #1;
    setAllOperands(200);
    rsp_ready = 1'b0;
    req_valid = '1;
    repeat (3) @(negedge clk);
    checkOutput("fill_rsp_valid", rsp_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rsp_valid", rsp_valid, 0);
    checkOutput("async_req_ready", req_ready, 0);
    checkOutput("async_op_count", op_count, 0);
    checkOutput("async_ovf_count", ovf_count, 0);
    checkOutput("async_rsp_sum", rsp_sum, 0);
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("post_rst_no_stale", rsp_valid, 0);
    end
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    checkOutput("post_rst_ptr_grant", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);

    // Counter saturation, then clear racing a handshake.
    doReset();
    @(posedge clk); #1;
    setAllOperands(0);
    req_valid = '1;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    checkOutput("sat_op_count", op_count, 16'hFFFF);
    checkOutput("sat_ovf_count", ovf_count, 0);
    @(negedge clk);
    checkOutput("sat_hold", op_count, 16'hFFFF);
    @(posedge clk); #1;
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    @(negedge clk);
    checkOutput("clr_priority", op_count, 0);
    @(negedge clk);
    checkOutput("post_clr_count", op_count, 1);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
